// File: rtl/decoder_pkg.sv
// Shared decode constants and the reference one-hot helper, so every block
// that turns an index into a strobe vector decodes identically.
package decoder_pkg;

    localparam int DEC_SEL_W = 3;
    localparam int DEC_OUT_W = 2 ** DEC_SEL_W;

    function automatic logic [DEC_OUT_W-1:0] onehot(input logic [DEC_SEL_W-1:0] sel);
        onehot = DEC_OUT_W'(1) << sel;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational index-to-one-hot decode with enable; all zeros when disabled.
module onehot_dec
    import decoder_pkg::*;
#(
    parameter int SEL_W = DEC_SEL_W,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             ena,
    input  logic [SEL_W-1:0] n,
    output logic [OUT_W-1:0] d_comb
);

    logic [OUT_W-1:0] hot;

    // The package helper is fixed-width, so other widths fall back to a compare bank.
    if (SEL_W == DEC_SEL_W) begin : g_pkg
        assign hot = onehot(n);
    end else begin : g_cmp
        always_comb begin
            hot = '0;
            for (int i = 0; i < OUT_W; i++) begin
                hot[i] = (n == i[SEL_W-1:0]);
            end
        end
    end

    assign d_comb = ena ? hot : '0;

endmodule

// File: rtl/decoder_3to8_reg.sv
// Registered binary-to-one-hot decoder with enable, optional active-low output
// polarity and a registered valid flag.
module decoder_3to8_reg
    import decoder_pkg::*;
#(
    parameter int SEL_W      = DEC_SEL_W,
    parameter bit ACTIVE_LOW = 1'b0,
    localparam int OUT_W     = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [SEL_W-1:0] n,
    output logic [OUT_W-1:0] d,
    output logic             d_valid
);

    // Idle level doubles as the polarity mask: a disabled decode is all zeros,
    // so XOR with it yields the idle pattern in either polarity.
    localparam logic [OUT_W-1:0] IDLE = {OUT_W{ACTIVE_LOW}};

    logic [OUT_W-1:0] d_comb;
    logic [OUT_W-1:0] d_p1;
    logic             vld_p1;

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .ena    (ena),
        .n      (n),
        .d_comb (d_comb)
    );

    // Stage p0 -> p1: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            d_p1   <= IDLE;
            vld_p1 <= 1'b0;
        end else begin
            d_p1   <= d_comb ^ IDLE;
            vld_p1 <= ena;
        end
    end

    assign d       = d_p1;
    assign d_valid = vld_p1;

endmodule

// File: tb/tb_decoder_3to8_reg.sv
// Randomized and directed bench for decoder_3to8_reg: default, active-low and
// 2-bit-index instances against an arithmetic reference model.
module tb_decoder_3to8_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] n;
    logic [1:0] n2;

    logic [7:0] d_hi;
    logic       v_hi;
    logic [7:0] d_lo;
    logic       v_lo;
    logic [3:0] d_w2;
    logic       v_w2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_3to8_reg u_dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .n       (n),
        .d       (d_hi),
        .d_valid (v_hi)
    );

    decoder_3to8_reg #(.ACTIVE_LOW(1'b1)) u_low (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .n       (n),
        .d       (d_lo),
        .d_valid (v_lo)
    );

    decoder_3to8_reg #(.SEL_W(2)) u_w2 (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .n       (n2),
        .d       (d_w2),
        .d_valid (v_w2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then compare every instance with the model.
    task automatic cycle(input logic r, input logic e, input logic [2:0] idx);
        logic [7:0] exp8;
        logic [3:0] exp4;
        logic       exp_v;
        rst = r;
        ena = e;
        n   = idx;
        n2  = idx[1:0];
        @(posedge clk);
        #1;
        exp_v = !r && e;
        exp8  = exp_v ? 8'(2 ** int'(idx)) : 8'd0;
        exp4  = exp_v ? 4'(2 ** int'(idx % 4)) : 4'd0;
        check("d", 32'(d_hi), 32'(exp8));
        check("d_valid", 32'(v_hi), 32'(exp_v));
        check("d_low", 32'(d_lo), 32'(8'hFF - exp8));
        check("d_valid_low", 32'(v_lo), 32'(exp_v));
        check("d_w2", 32'(d_w2), 32'(exp4));
        check("d_valid_w2", 32'(v_w2), 32'(exp_v));
        if (v_w2 === 1'b1)
            check("w2_onehot", 32'($countones(d_w2)), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b0;
        n   = '0;
        n2  = '0;

        // reset held with an enabled index
        cycle(1'b1, 1'b1, 3'd5);
        cycle(1'b1, 1'b1, 3'd5);

        // full sweep
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b1, 3'(i));

        // disabled: index must not leak through
        cycle(1'b0, 1'b0, 3'd3);
        cycle(1'b0, 1'b0, 3'd7);

        // reset mid-stream then resume
        cycle(1'b0, 1'b1, 3'd6);
        cycle(1'b1, 1'b1, 3'd2);
        cycle(1'b0, 1'b1, 3'd2);

        // active-low points and 2-bit extremes
        cycle(1'b0, 1'b1, 3'd4);
        cycle(1'b0, 1'b0, 3'd4);
        cycle(1'b1, 1'b1, 3'd4);
        cycle(1'b0, 1'b1, 3'd3);
        cycle(1'b0, 1'b1, 3'd0);

        // random traffic with occasional reset
        for (int k = 0; k < 300; k++)
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_3to8_reg.md
Name: decoder_3to8_reg

Overview:
- Registered binary-to-one-hot decoder with enable. Default configuration is 3-bit index to 8-bit one-hot output.
- Used wherever a select index must become a one-hot strobe vector, e.g. register-bank write enables or mux selects.
- Output is registered on the single clock and cleared by a synchronous active-high reset.

Parameters:
- SEL_W, 3, width of index input n.
- OUT_W, 2**SEL_W, width of decoded output d. Derived; must not be overridden independently.
- ACTIVE_LOW, 0. When 1, d is driven inverted: one-cold when enabled, all ones when disabled or in reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  decode enable.
- n  input  SEL_W  binary index to decode.
- d  output  OUT_W  registered decoded vector.
- d_valid  output  1  registered copy of ena. High when d reflects an enabled decode.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - On a rising clk edge with rst=1: d <= all zeros (all ones if ACTIVE_LOW=1) and d_valid <= 0.
  - rst has priority over ena and n.
- Enabled decode:
  - On a rising clk edge with rst=0 and ena=1: d <= 1 << n (bit n set, all others clear), and d_valid <= 1.
  - With ACTIVE_LOW=1, d <= ~(1 << n).
- Disabled:
  - On a rising clk edge with rst=0 and ena=0: d <= all zeros (all ones if ACTIVE_LOW=1), and d_valid <= 0.
  - n is don't-care and must not affect d.
- Latency: exactly 1 cycle from ena/n sampled to d/d_valid. No combinational path from inputs to outputs.
- Throughput: a new index every cycle. Back-to-back distinct n produce back-to-back distinct one-hot outputs.
- Invariant: with ACTIVE_LOW=0 and d_valid=1, exactly one bit of d is set. With d_valid=0, d is zero.
- Full range: every value 0..OUT_W-1 is legal. There is no out-of-range case because OUT_W = 2**SEL_W.
- Reset mid-operation: the reset cycle overrides any enabled decode. The next non-reset edge resumes normal decoding with no extra latency.
- Before the first reset the outputs are unspecified. The bench must apply reset first.

Decomposition:
- Shared package decoder_pkg holds:
  - the SEL_W default constant;
  - a helper function onehot(sel) returning the OUT_W one-hot vector, so other blocks decode identically.
- One natural sub-module: onehot_dec.
  - Purely combinational.
  - Ports: ena, n, d_comb.
  - Implements the enable plus shift/compare logic.
- Top level decoder_3to8_reg adds:
  - the output register;
  - the reset mux;
  - ACTIVE_LOW inversion;
  - the d_valid flop.

Test Plan:
- Reset: hold rst=1 for 2 cycles with ena=1, n=5 -> d=00000000, d_valid=0 after each edge.
- Full sweep: rst=0, ena=1, n=0,1,...,7 on consecutive cycles -> d one cycle later = 00000001, 00000010, 00000100, 00001000, 00010000, 00100000, 01000000, 10000000; d_valid=1 throughout.
- Disable: after the sweep set ena=0, n=3 then n=7 -> d=00000000, d_valid=0 on both following cycles.
- Reset mid-stream: ena=1, n=6, then assert rst for one cycle while n=2 -> d=01000000, then 00000000; deassert rst with n=2 -> next d=00000100.
- ACTIVE_LOW=1 instance: ena=1, n=4 -> d=11101111; ena=0 -> d=11111111; rst -> d=11111111.
- SEL_W=2 instance: ena=1, n=3 -> d=1000; n=0 -> d=0001; every output cycle with d_valid=1 has a one-hot d (checked by assertion).
